// File: rtl/mdio_pkg.sv
// mdio_pkg: shared constants and types for the Clause 22 MDIO responder.
//   - frame field patterns (start, opcodes, write turnaround)
//   - field widths, frame length and preamble length
//   - FSM state enumeration
package mdio_pkg;

  localparam int DATA_W       = 16;
  localparam int PHYAD_W      = 5;
  localparam int REGAD_W      = 5;
  localparam int FRAME_LEN    = 32;
  localparam int PREAMBLE_LEN = 32;

  localparam logic [1:0] ST_PATTERN = 2'b01;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_READ    = 2'b10;
  localparam logic [1:0] TA_WRITE   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_ST    = 4'd1,
    S_OP    = 4'd2,
    S_PHY   = 4'd3,
    S_REG   = 4'd4,
    S_TA    = 4'd5,
    S_WDATA = 4'd6,
    S_RDATA = 4'd7,
    S_SKIP  = 4'd8
  } mdio_state_e;

endpackage

// File: rtl/mdio_shift16.sv
// mdio_shift16: 16-bit shift register with parallel load, serial in (LSB
// side) and serial out (MSB, via q). Used both to capture write data and to
// serialise read data.
//   clk, rst_n : MDC and asynchronous active-low reset
//   load_en    : load load_val (has priority over shift_en)
//   shift_en   : shift left by one, sin enters at bit 0
//   q          : current register contents
module mdio_shift16
  import mdio_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [DATA_W-1:0] load_val,
  input  logic              shift_en,
  input  logic              sin,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] sh_q;
  logic [DATA_W-1:0] sh_d;

  always_comb begin
    sh_d = sh_q;
    if (load_en) begin
      sh_d = load_val;
    end else if (shift_en) begin
      sh_d = {sh_q[DATA_W-2:0], sin};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign q = sh_q;

endmodule

// File: rtl/mdio_responder.sv
// mdio_responder: PHY-side Clause 22 MDIO frame decoder.
// Bits are sampled on the rising edge of MDC (clk). Write frames produce a
// one-cycle wr_stb with addr/wr_data; read frames produce a one-cycle rd_stb
// and serialise rd_data back on mdio_out/mdio_oe. Aborted frames pulse err_stb.
//   clk, rst_n         : MDC and asynchronous active-low reset
//   mdio_in            : sampled MDIO line
//   mdio_out, mdio_oe  : responder drive value and tri-state enable
//   addr, wr_data      : register address / write data of the last frame
//   wr_stb, rd_stb     : one-cycle write strobe / read request
//   rd_data            : read data, sampled the cycle after rd_stb
//   err_stb            : one-cycle pulse on an aborted frame
// Optional: define MDIO_PREAMBLE_CHECK_EN to require 32 consecutive 1s
// before a start bit is accepted.
module mdio_responder
  import mdio_pkg::*;
#(
  parameter logic [PHYAD_W-1:0] PHY_ADDR = 5'h01
)
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mdio_in,
  output logic               mdio_out,
  output logic               mdio_oe,
  output logic [REGAD_W-1:0] addr,
  output logic [DATA_W-1:0]  wr_data,
  output logic               wr_stb,
  output logic               rd_stb,
  input  logic [DATA_W-1:0]  rd_data,
  output logic               err_stb
);

  localparam logic [3:0] IDLE  = S_IDLE;
  localparam logic [3:0] ST    = S_ST;
  localparam logic [3:0] OP    = S_OP;
  localparam logic [3:0] PHY   = S_PHY;
  localparam logic [3:0] REG   = S_REG;
  localparam logic [3:0] TA    = S_TA;
  localparam logic [3:0] WDATA = S_WDATA;
  localparam logic [3:0] RDATA = S_RDATA;
  localparam logic [3:0] SKIP  = S_SKIP;

  localparam logic [5:0] BIT_OP_LAST  = 6'd4;
  localparam logic [5:0] BIT_PHY_LAST = 6'd9;
  localparam logic [5:0] BIT_REG_LAST = 6'd14;
  localparam logic [5:0] BIT_TA_FIRST = 6'd15;
  localparam logic [5:0] BIT_LAST     = 6'(FRAME_LEN);

  logic [3:0]         state_q, state_d;
  logic [5:0]         bit_cnt_q, bit_cnt_d;   // number of the bit sampled this edge
  logic [3:0]         field_q, field_d;       // last four sampled bits
  logic [1:0]         op_q, op_d;
  logic [REGAD_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic               wr_stb_q, wr_stb_d;
  logic               rd_stb_q, rd_stb_d;
  logic               err_stb_q, err_stb_d;
  logic               mdio_oe_q, mdio_oe_d;
  logic               mdio_out_q, mdio_out_d;

  logic               sh_load, sh_shift;
  logic [DATA_W-1:0]  sh_q;
  logic [4:0]         field_now;              // field ending in the current bit

`ifdef MDIO_PREAMBLE_CHECK_EN
  logic [5:0]         pre_cnt_q, pre_cnt_d;
`endif

  assign field_now = {field_q, mdio_in};

  mdio_shift16 u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_en  (sh_load),
    .load_val (rd_data),
    .shift_en (sh_shift),
    .sin      (mdio_in),
    .q        (sh_q)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q + 6'd1;
    field_d    = field_now[3:0];
    op_d       = op_q;
    addr_d     = addr_q;
    wr_data_d  = wr_data_q;
    wr_stb_d   = 1'b0;
    rd_stb_d   = 1'b0;
    err_stb_d  = 1'b0;
    mdio_oe_d  = mdio_oe_q;
    mdio_out_d = mdio_out_q;
    sh_load    = 1'b0;
    sh_shift   = 1'b0;
`ifdef MDIO_PREAMBLE_CHECK_EN
    pre_cnt_d  = pre_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        // The start bit just sampled is bit 1, so the next edge samples bit 2.
        bit_cnt_d  = 6'd2;
        mdio_oe_d  = 1'b0;
        mdio_out_d = 1'b0;
`ifdef MDIO_PREAMBLE_CHECK_EN
        if (mdio_in) begin
          pre_cnt_d = (pre_cnt_q == 6'h3F) ? pre_cnt_q : pre_cnt_q + 6'd1;
        end else begin
          // Short preamble: the 0 is silently dropped.
          pre_cnt_d = '0;
          if (pre_cnt_q >= 6'(PREAMBLE_LEN)) state_d = ST;
        end
`else
        if (!mdio_in) state_d = ST;
`endif
      end

      ST: begin
        if ({1'b0, mdio_in} == ST_PATTERN) begin
          state_d = OP;
        end else begin
          err_stb_d = 1'b1;
          state_d   = IDLE;
        end
      end

      OP: begin
        if (bit_cnt_q == BIT_OP_LAST) begin
          op_d = field_now[1:0];
          if (field_now[1:0] == OP_WRITE || field_now[1:0] == OP_READ) begin
            state_d = PHY;
          end else begin
            err_stb_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end

      PHY: begin
        if (bit_cnt_q == BIT_PHY_LAST) begin
          state_d = (field_now == PHY_ADDR) ? REG : SKIP;
        end
      end

      REG: begin
        if (bit_cnt_q == BIT_REG_LAST) begin
          addr_d   = field_now;
          rd_stb_d = (op_q == OP_READ);
          state_d  = TA;
        end
      end

      TA: begin
        if (bit_cnt_q == BIT_TA_FIRST) begin
          if (op_q == OP_READ) begin
            // Capture read data and drive the PHY half of the turnaround.
            sh_load    = 1'b1;
            mdio_oe_d  = 1'b1;
            mdio_out_d = 1'b0;
          end
        end else if (op_q == OP_READ) begin
          mdio_out_d = sh_q[DATA_W-1];
          sh_shift   = 1'b1;
          state_d    = RDATA;
        end else if (field_now[1:0] == TA_WRITE) begin
          state_d = WDATA;
        end else begin
          err_stb_d = 1'b1;
          state_d   = IDLE;
        end
      end

      WDATA: begin
        sh_shift = 1'b1;
        if (bit_cnt_q == BIT_LAST) begin
          wr_data_d = {sh_q[DATA_W-2:0], mdio_in};
          wr_stb_d  = 1'b1;
          state_d   = IDLE;
        end
      end

      RDATA: begin
        if (bit_cnt_q == BIT_LAST) begin
          mdio_oe_d  = 1'b0;
          mdio_out_d = 1'b0;
          state_d    = IDLE;
        end else begin
          mdio_out_d = sh_q[DATA_W-1];
          sh_shift   = 1'b1;
        end
      end

      SKIP: begin
        if (bit_cnt_q == BIT_LAST) state_d = IDLE;
      end

      default: begin
        mdio_oe_d  = 1'b0;
        mdio_out_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      field_q    <= '0;
      op_q       <= '0;
      addr_q     <= '0;
      wr_data_q  <= '0;
      wr_stb_q   <= 1'b0;
      rd_stb_q   <= 1'b0;
      err_stb_q  <= 1'b0;
      mdio_oe_q  <= 1'b0;
      mdio_out_q <= 1'b0;
`ifdef MDIO_PREAMBLE_CHECK_EN
      pre_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      field_q    <= field_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
      wr_stb_q   <= wr_stb_d;
      rd_stb_q   <= rd_stb_d;
      err_stb_q  <= err_stb_d;
      mdio_oe_q  <= mdio_oe_d;
      mdio_out_q <= mdio_out_d;
`ifdef MDIO_PREAMBLE_CHECK_EN
      pre_cnt_q  <= pre_cnt_d;
`endif
    end
  end

  assign mdio_out = mdio_out_q;
  assign mdio_oe  = mdio_oe_q;
  assign addr     = addr_q;
  assign wr_data  = wr_data_q;
  assign wr_stb   = wr_stb_q;
  assign rd_stb   = rd_stb_q;
  assign err_stb  = err_stb_q;

endmodule

// File: tb/tb_mdio_responder.sv
// tb_mdio_responder: drives MDIO bit streams into mdio_responder and checks
// every cycle against a frame-level model of the protocol, plus literal
// expectations from the directed frames.
module tb_mdio_responder;

`ifdef MDIO_PREAMBLE_CHECK_EN
  localparam int PRE_N = 32;
`else
  localparam int PRE_N = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mdio_in = 1'b1;
  logic [15:0] rd_data = 16'h0;
  logic        mdio_out, mdio_oe, wr_stb, rd_stb, err_stb;
  logic [4:0]  addr;
  logic [15:0] wr_data;

  always #5 clk = ~clk;

  mdio_responder #(.PHY_ADDR(5'h01)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mdio_in  (mdio_in),
    .mdio_out (mdio_out),
    .mdio_oe  (mdio_oe),
    .addr     (addr),
    .wr_data  (wr_data),
    .wr_stb   (wr_stb),
    .rd_stb   (rd_stb),
    .rd_data  (rd_data),
    .err_stb  (err_stb)
  );

  int total = 0;
  int bad   = 0;

  // Stimulus stream: s[e] is sampled at edge e; rdv[e] is on rd_data then.
  bit          s[$];
  logic [15:0] rdv[$];

  // Expected DUT outputs just after edge e.
  bit          xe_oe[], xe_out[], xe_wr[], xe_rd[], xe_err[];
  logic [4:0]  xe_addr[];
  logic [15:0] xe_wd[];

  int cur_e = 0;
  bit chk_pend = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_pend) begin
      chk_pend = 1'b0;
      total++;
      if ({mdio_oe, mdio_out, wr_stb, rd_stb, err_stb} !==
          {xe_oe[cur_e], xe_out[cur_e], xe_wr[cur_e], xe_rd[cur_e], xe_err[cur_e]} ||
          addr !== xe_addr[cur_e] || wr_data !== xe_wd[cur_e]) begin
        bad++;
        $display("FAIL cycle e=%0d got oe=%b out=%b wr=%b rd=%b err=%b addr=%h wd=%h exp oe=%b out=%b wr=%b rd=%b err=%b addr=%h wd=%h",
                 cur_e, mdio_oe, mdio_out, wr_stb, rd_stb, err_stb, addr, wr_data,
                 xe_oe[cur_e], xe_out[cur_e], xe_wr[cur_e], xe_rd[cur_e], xe_err[cur_e],
                 xe_addr[cur_e], xe_wd[cur_e]);
      end
    end
  end

  task automatic push_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) s.push_back(v[i]);
  endtask

  task automatic push_idle(input int n);
    repeat (n) s.push_back(1'b1);
  endtask

  task automatic push_frame(input logic [1:0] st, input logic [1:0] op, input logic [4:0] phy,
                            input logic [4:0] rg, input logic [1:0] ta, input logic [15:0] d);
    push_bits({st, op, phy, rg, ta, d}, 32);
  endtask

  task automatic fill_rdv(input bit rnd, input logic [15:0] c);
    rdv.delete();
    for (int i = 0; i < s.size(); i++) rdv.push_back(rnd ? 16'($urandom) : c);
  endtask

  // Bit k (1-based) of a frame starting at stream index p.
  function automatic bit fb(input int p, input int k);
    int i = p + k - 1;
    return (i < s.size()) ? s[i] : 1'b1;
  endfunction

  function automatic logic [15:0] fld(input int p, input int k0, input int w);
    logic [15:0] v = 16'h0;
    for (int i = 0; i < w; i++) v = {v[14:0], fb(p, k0 + i)};
    return v;
  endfunction

  function automatic int count1(input bit a[]);
    int c = 0;
    foreach (a[i]) c += int'(a[i]);
    return c;
  endfunction

  // Frame-level model: walks the stream frame by frame and records when each
  // observable effect must appear.
  task automatic build_expect();
    int n = s.size();
    int p = 0;
    int ones = 0;
    logic [1:0]  op;
    logic [15:0] t, d;
    logic [4:0]  a_run = 5'h0;
    logic [15:0] w_run = 16'h0;
    bit          av[], wv[];
    logic [4:0]  aval[];
    logic [15:0] wval[];
    xe_oe = new[n]; xe_out = new[n]; xe_wr = new[n]; xe_rd = new[n]; xe_err = new[n];
    xe_addr = new[n]; xe_wd = new[n];
    av = new[n]; wv = new[n]; aval = new[n]; wval = new[n];
    for (int i = 0; i < n; i++) begin
      xe_oe[i] = 0; xe_out[i] = 0; xe_wr[i] = 0; xe_rd[i] = 0; xe_err[i] = 0;
      av[i] = 0; wv[i] = 0; aval[i] = 5'h0; wval[i] = 16'h0;
    end
    while (p < n) begin
      if (s[p]) begin ones++; p++; continue; end
      if (ones < PRE_N) begin ones = 0; p++; continue; end
      ones = 0;
      if (fb(p, 2) != 1'b1) begin
        if (p + 1 < n) xe_err[p + 1] = 1;
        p += 2; continue;
      end
      t = fld(p, 3, 2); op = t[1:0];
      if (op != 2'b01 && op != 2'b10) begin
        if (p + 3 < n) xe_err[p + 3] = 1;
        p += 4; continue;
      end
      t = fld(p, 5, 5);
      if (t[4:0] != 5'h01) begin p += 32; continue; end
      t = fld(p, 10, 5);
      if (p + 13 < n) begin av[p + 13] = 1; aval[p + 13] = t[4:0]; end
      if (op == 2'b10) begin
        if (p + 13 < n) xe_rd[p + 13] = 1;
        d = (p + 14 < n) ? rdv[p + 14] : 16'h0;
        for (int k = 15; k <= 31; k++) begin
          if (p + k - 1 < n) begin
            xe_oe[p + k - 1]  = 1;
            xe_out[p + k - 1] = (k == 15) ? 1'b0 : d[31 - k];
          end
        end
        p += 32;
      end else begin
        t = fld(p, 15, 2);
        if (t[1:0] != 2'b10) begin
          if (p + 15 < n) xe_err[p + 15] = 1;
          p += 16; continue;
        end
        d = fld(p, 17, 16);
        if (p + 31 < n) begin xe_wr[p + 31] = 1; wv[p + 31] = 1; wval[p + 31] = d; end
        p += 32;
      end
    end
    for (int i = 0; i < n; i++) begin
      if (av[i]) a_run = aval[i];
      if (wv[i]) w_run = wval[i];
      xe_addr[i] = a_run;
      xe_wd[i]   = w_run;
    end
  endtask

  // Reset, then play the stream edge by edge; the compare process checks
  // the outputs after every edge.
  task automatic run_stream(input string name);
    build_expect();
    @(negedge clk);
    rst_n = 1'b0; mdio_in = 1'b1;
    #1;
    chk({name, " reset outputs"}, {mdio_oe, mdio_out, wr_stb, rd_stb, err_stb, addr, wr_data}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 0; e < s.size(); e++) begin
      if (e > 0) @(negedge clk);
      mdio_in = s[e];
      rd_data = rdv[e];
      @(posedge clk);
      #1;
      cur_e = e;
      chk_pend = 1'b1;
    end
    @(negedge clk);
    #1;
    $display("stream %s: edges=%0d wr=%0d rd=%0d err=%0d", name, s.size(),
             count1(xe_wr), count1(xe_rd), count1(xe_err));
  endtask

  logic [31:0] fr;
  logic [4:0]  rphy, rrg;
  logic [1:0]  rop, rta;

  initial begin
    // Directed write: addr 3, data A5C3.
    s.delete(); push_idle(PRE_N); push_frame(2'b01, 2'b01, 5'h01, 5'h03, 2'b10, 16'hA5C3);
    push_idle(3); fill_rdv(1, 16'h0);
    run_stream("write");
    chk("model wr pos", {31'h0, xe_wr[PRE_N + 31]}, 32'h1);
    chk("model wr early", {31'h0, xe_wr[PRE_N + 30]}, 32'h0);
    chk("model wd", {16'h0, xe_wd[PRE_N + 31]}, 32'h0000A5C3);
    chk("dut wr_data", {16'h0, wr_data}, 32'h0000A5C3);
    chk("dut addr write", {27'h0, addr}, 32'h3);

    // Directed read: addr 7, rd_data BEEF.
    s.delete(); push_idle(PRE_N); push_frame(2'b01, 2'b10, 5'h01, 5'h07, 2'b11, 16'hFFFF);
    push_idle(2); fill_rdv(0, 16'hBEEF);
    run_stream("read");
    chk("model rd pos", {31'h0, xe_rd[PRE_N + 13]}, 32'h1);
    chk("model ta drive", {30'h0, xe_oe[PRE_N + 14], xe_out[PRE_N + 14]}, 32'h2);
    chk("model bit16", {31'h0, xe_out[PRE_N + 15]}, 32'h1);
    chk("model bit17", {31'h0, xe_out[PRE_N + 16]}, 32'h0);
    chk("model oe off", {31'h0, xe_oe[PRE_N + 31]}, 32'h0);
    chk("dut addr read", {27'h0, addr}, 32'h7);

    // PHY mismatch followed by a valid write.
    s.delete();
    push_idle(PRE_N); push_frame(2'b01, 2'b01, 5'h02, 5'h03, 2'b10, 16'h1234);
    push_idle(PRE_N); push_frame(2'b01, 2'b01, 5'h01, 5'h05, 2'b10, 16'h5678);
    push_idle(2); fill_rdv(1, 16'h0);
    run_stream("mismatch");
    chk("model mismatch no wr", {31'h0, xe_wr[PRE_N + 31]}, 32'h1 - 32'h1);
    chk("model second wr", {31'h0, xe_wr[2 * PRE_N + 63]}, 32'h1);
    chk("dut mismatch wd", {16'h0, wr_data}, 32'h00005678);

    // Bad TA then valid write; bad OP then valid write.
    s.delete();
    push_idle(PRE_N); push_bits({2'b01, 2'b01, 5'h01, 5'h04, 2'b11}, 16);
    push_idle(PRE_N); push_frame(2'b01, 2'b01, 5'h01, 5'h04, 2'b10, 16'h2222);
    push_idle(PRE_N); push_bits({2'b01, 2'b11}, 4);
    push_idle(PRE_N); push_frame(2'b01, 2'b01, 5'h01, 5'h0A, 2'b10, 16'h3333);
    push_idle(2); fill_rdv(1, 16'h0);
    run_stream("aborts");
    chk("model ta err", {31'h0, xe_err[PRE_N + 15]}, 32'h1);
    chk("model err count", count1(xe_err), 32'd2);
    chk("model wr count", count1(xe_wr), 32'd2);
    chk("dut aborts wd", {16'h0, wr_data}, 32'h00003333);

    // Reset in the middle of a read (after bit 20), then a fresh read.
    s.delete(); push_idle(PRE_N);
    fr = {2'b01, 2'b10, 5'h01, 5'h09, 2'b11, 16'hFFFF};
    push_bits(fr >> 12, 20); fill_rdv(0, 16'h8001);
    run_stream("read cut");
    chk("model oe mid read", {31'h0, xe_oe[PRE_N + 19]}, 32'h1);
    chk("dut oe before reset", {31'h0, mdio_oe}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("dut oe/out at reset", {30'h0, mdio_oe, mdio_out}, 32'h0);
    s.delete(); push_idle(PRE_N); push_frame(2'b01, 2'b10, 5'h01, 5'h09, 2'b11, 16'hFFFF);
    push_idle(2); fill_rdv(1, 16'h0);
    run_stream("read after reset");

    // Short versus full preamble in front of the same write.
    s.delete();
    push_idle(31); push_frame(2'b01, 2'b01, 5'h01, 5'h06, 2'b10, 16'h0F0F);
    push_idle(32); push_frame(2'b01, 2'b01, 5'h01, 5'h06, 2'b10, 16'h0F0F);
    push_idle(2); fill_rdv(1, 16'h0);
    run_stream("preamble");
`ifdef MDIO_PREAMBLE_CHECK_EN
    chk("model preamble wr count", count1(xe_wr), 32'd1);
`else
    chk("model preamble wr count", count1(xe_wr), 32'd2);
`endif
    chk("dut preamble wd", {16'h0, wr_data}, 32'h00000F0F);

    // Randomised mixtures of good, foreign, aborted and garbage frames.
    for (int r = 0; r < 6; r++) begin
      s.delete();
      for (int f = 0; f < 14; f++) begin
        if (PRE_N > 0 && $urandom_range(0, 5) == 0) push_idle(int'($urandom_range(20, 31)));
        else push_idle(PRE_N + int'($urandom_range(0, 3)));
        rrg  = 5'($urandom);
        rphy = 5'($urandom_range(2, 32));
        rop  = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
        case ($urandom_range(0, 6))
          0: push_frame(2'b01, 2'b01, 5'h01, rrg, 2'b10, 16'($urandom));
          1: push_frame(2'b01, 2'b10, 5'h01, rrg, 2'($urandom), 16'($urandom));
          2: push_frame(2'b01, rop, rphy, rrg, 2'b10, 16'($urandom));
          3: push_bits(32'h0, 2);
          4: push_bits({2'b01, (($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00)}, 4);
          5: begin
            rta = 2'($urandom_range(0, 2));
            if (rta == 2'b10) rta = 2'b11;
            push_bits({2'b01, 2'b01, 5'h01, rrg, rta}, 16);
          end
          default: push_bits($urandom, 32);
        endcase
      end
      push_idle(3); fill_rdv(1, 16'h0);
      run_stream($sformatf("random%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdio_responder.md
Name: mdio_responder

Overview:
- PHY-side (responder) end of an IEEE 802.3 Clause 22 MDIO management interface; the station-management controller is the initiator.
- Decodes serial frames on MDIO sampled at MDC.
- Write frames: presents a register address plus data and a one-cycle write strobe to an external register file.
- Read frames: requests data from that register file and serialises it back on MDIO.

Parameters:
- PHY_ADDR, 5'h01, PHY address this responder answers to.
- DATA_W, 16, register data width; fixed at 16 by protocol, exposed for the package only.

Ports:
- clk  input  1  MDC; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mdio_in  input  1  MDIO line as seen by the responder.
- mdio_out  output  1  value driven on MDIO when mdio_oe=1.
- mdio_oe  output  1  tri-state enable for MDIO.
- addr  output  5  register address of current/last frame.
- wr_data  output  16  write data of last write frame.
- wr_stb  output  1  one-cycle write strobe.
- rd_stb  output  1  one-cycle read request.
- rd_data  input  16  read data; must be valid the cycle after rd_stb.
- err_stb  output  1  one-cycle pulse on aborted frame.

Behaviour:
- Reset (asynchronous, any state, including mid-frame):
  - state=IDLE.
  - All outputs 0.
  - mdio_oe drops immediately.
- Frame bit numbering (1-based, first start bit = 1):
  - ST 1-2 = "01".
  - OP 3-4: "01" write, "10" read.
  - PHYAD 5-9, MSB first.
  - REGAD 10-14, MSB first.
  - TA 15-16.
  - DATA 17-32, MSB first.
- States: IDLE, ST, OP, PHY, REG, TA, WDATA, RDATA, SKIP.
- IDLE:
  - Sampling 1 stays in IDLE.
  - Sampling 0 goes to ST.
- ST / OP aborts:
  - ST second bit not 1: err_stb, go to IDLE.
  - Illegal OP ("00"/"11"): err_stb after bit 4, go to IDLE.
  - Resync on the next 0.
- PHY address mismatch:
  - Enter SKIP; count remaining bits up to bit 32, then go to IDLE.
  - No strobes, no err_stb, mdio_oe never asserted.
- addr update: addr takes REGAD in the cycle after bit 14 is sampled.
- Read, cycle-level:
  - rd_stb=1 in the cycle after bit 14.
  - rd_data is latched into the shift register at the bit-15 edge.
  - After the bit-15 edge: mdio_oe=1, mdio_out=0 (PHY-driven TA bit).
  - After the bit-k edge (k=16..31): mdio_out=data[31-k].
  - After the bit-32 edge: mdio_oe=0, go to IDLE.
  - TA bit-15 value is not checked.
- Write, cycle-level:
  - TA must sample "10"; otherwise err_stb and go to IDLE.
  - Data shifts in over bits 17-32.
  - In the cycle after the bit-32 sample: wr_stb=1 for one cycle, with wr_data and addr stable. wr_data holds until the next write.
- Back-to-back frames: a start 0 is accepted in the very cycle after bit 32 (no preamble needed).
- Strobe exclusivity: wr_stb, rd_stb and err_stb are mutually exclusive and never asserted twice per frame.
- Outputs are registered; no combinational path from mdio_in to any output.

Optional Feature:
- Macro: MDIO_PREAMBLE_CHECK_EN.
- Defined:
  - IDLE holds a 6-bit saturating counter of consecutive 1 samples.
  - A 0 is a start bit only if the counter has reached 32; a 0 earlier clears the counter and is ignored (no err_stb).
  - Counter is cleared on frame entry and on reset.
- Undefined: no counter; any 0 in IDLE starts a frame.

Decomposition:
- Package mdio_pkg:
  - state enum.
  - OP_WRITE=2'b01, OP_READ=2'b10.
  - ST_PATTERN=2'b01, TA_WRITE=2'b10.
  - Field widths: PHYAD_W=5, REGAD_W=5, DATA_W=16.
  - Frame length 32; preamble length 32.
- One sub-module, mdio_shift16:
  - 16-bit register with parallel load, serial in and serial out.
  - Shared for write capture and read serialisation.
- FSM and bit counter live in mdio_responder.

Test Plan:
- Write: 01 01 00001 00011 10 A5C3h → one wr_stb in cycle after bit 32, addr=3, wr_data=A5C3h, mdio_oe never 1.
- Read: 01 10 00001 00111, rd_data=BEEFh → rd_stb after bit 14 with addr=7; mdio_oe high bits 16-32; mdio_out = 0 then BEEFh MSB first; oe low after bit 32.
- PHY mismatch write with PHYAD 00010, then valid write to 00001 → first frame gives no strobes; second frame's wr_stb fires at cycle 64.
- Write with TA "11", and separately OP "11" → err_stb once, no wr_stb, next valid frame decoded.
- Reset asserted at bit 20 of a read → mdio_oe/mdio_out 0 immediately; after release, a new read returns correct data.
- MDIO_PREAMBLE_CHECK_EN: 31 ones + write frame → ignored; 32 ones + same frame → wr_stb, correct data.
